// File: rtl/rs_mul.sv
// -----------------------------------------------------------------------------
// rs_mul -- reservation station in front of the integer multiplier.
//
// Holds up to ENTRY_NUM multiply operations that wait for their source operands.
// Operands that are not ready at dispatch capture their value from the common
// data bus (CDB) when the producer tag is broadcast. Each cycle the
// lowest-indexed entry with both operands ready is offered to the multiplier.
//
// Optional feature (macro RS_MUL_DP_BYPASS_EN):
//   When defined, a dispatch whose operands are both ready (including a
//   same-cycle CDB capture) is issued straight to the multiplier in the
//   dispatch cycle without allocating an entry. This happens only when no
//   stored entry is ready and the multiplier accepts issue. Without the macro,
//   every accepted dispatch allocates an entry.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   i_dp_*                dispatch request, controls, operands, tags, ROB tag
//   o_dp_ready            at least one free entry (registered state only)
//   i_cdb_vld/tag/data    result broadcast used to wake waiting operands
//   i_kill                flush: drop every entry and any same-cycle dispatch
//   i_ex_accessable       multiplier can take an issue this cycle
//   o_is_vld, o_*         issue strobe and payload (payload zero when idle)
//   o_empty               no valid entries
// -----------------------------------------------------------------------------
module rs_mul #(
    parameter int ENTRY_NUM = 4,
    parameter int TAG_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // dispatch
    input  logic                 i_dp_vld,
    output logic                 o_dp_ready,
    input  logic                 i_dp_signed1,
    input  logic                 i_dp_signed2,
    input  logic                 i_dp_sel_high,
    input  logic [31:0]          i_dp_src1,
    input  logic [31:0]          i_dp_src2,
    input  logic                 i_dp_src1_rdy,
    input  logic                 i_dp_src2_rdy,
    input  logic [TAG_WIDTH-1:0] i_dp_src1_tag,
    input  logic [TAG_WIDTH-1:0] i_dp_src2_tag,
    input  logic [TAG_WIDTH-1:0] i_dp_rob_tag,
    // result broadcast
    input  logic                 i_cdb_vld,
    input  logic [TAG_WIDTH-1:0] i_cdb_tag,
    input  logic [31:0]          i_cdb_data,
    // control
    input  logic                 i_kill,
    input  logic                 i_ex_accessable,
    // issue
    output logic                 o_is_vld,
    output logic                 o_signed1,
    output logic                 o_signed2,
    output logic                 o_sel_high,
    output logic [31:0]          o_src1,
    output logic [31:0]          o_src2,
    output logic [TAG_WIDTH-1:0] o_is_rob_tag,
    output logic                 o_empty
);

    localparam int DATA_W = 32;
    localparam int IDX_W  = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

    // control state (reset)
    logic [ENTRY_NUM-1:0] valid_q, valid_d;
    logic [ENTRY_NUM-1:0] rdy1_q, rdy1_d;
    logic [ENTRY_NUM-1:0] rdy2_q, rdy2_d;

    // payload state (no reset: only meaningful while the entry is valid)
    logic [ENTRY_NUM-1:0] sgn1_q, sgn1_d;
    logic [ENTRY_NUM-1:0] sgn2_q, sgn2_d;
    logic [ENTRY_NUM-1:0] selh_q, selh_d;
    logic signed [DATA_W-1:0] val1_q [ENTRY_NUM];
    logic signed [DATA_W-1:0] val1_d [ENTRY_NUM];
    logic signed [DATA_W-1:0] val2_q [ENTRY_NUM];
    logic signed [DATA_W-1:0] val2_d [ENTRY_NUM];
    logic [TAG_WIDTH-1:0] tag1_q [ENTRY_NUM];
    logic [TAG_WIDTH-1:0] tag1_d [ENTRY_NUM];
    logic [TAG_WIDTH-1:0] tag2_q [ENTRY_NUM];
    logic [TAG_WIDTH-1:0] tag2_d [ENTRY_NUM];
    logic [TAG_WIDTH-1:0] rob_q  [ENTRY_NUM];
    logic [TAG_WIDTH-1:0] rob_d  [ENTRY_NUM];

    // selection
    logic [ENTRY_NUM-1:0] ready_vec;
    logic                 any_ready;
    logic                 any_free;
    logic [IDX_W-1:0]     is_idx;
    logic [IDX_W-1:0]     free_idx;

    // dispatch operands after same-cycle CDB capture
    logic                     dp_rdy1, dp_rdy2;
    logic signed [DATA_W-1:0] dp_val1, dp_val2;
    logic                     dp_accept;
    logic                     bypass;
    logic                     alloc;
    logic                     issue_rs;

    // -------------------------------------------------------------------------
    // Entry selection: lowest-indexed ready entry and lowest-indexed free entry.
    // Scanning from the top down lets the lowest index win the last assignment.
    // -------------------------------------------------------------------------
    always_comb begin
        ready_vec = valid_q & rdy1_q & rdy2_q;
        any_ready = |ready_vec;
        any_free  = ~&valid_q;
        is_idx    = '0;
        free_idx  = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (ready_vec[i]) is_idx   = i[IDX_W-1:0];
            if (!valid_q[i])  free_idx = i[IDX_W-1:0];
        end
    end

    // -------------------------------------------------------------------------
    // Dispatch handling. A dispatched operand can be satisfied by the CDB in the
    // very cycle it is dispatched, otherwise it would miss its only broadcast.
    // -------------------------------------------------------------------------
    always_comb begin
        dp_rdy1 = i_dp_src1_rdy | (i_cdb_vld & (i_dp_src1_tag == i_cdb_tag));
        dp_rdy2 = i_dp_src2_rdy | (i_cdb_vld & (i_dp_src2_tag == i_cdb_tag));
        dp_val1 = i_dp_src1_rdy ? i_dp_src1 : i_cdb_data;
        dp_val2 = i_dp_src2_rdy ? i_dp_src2 : i_cdb_data;
    end

    assign dp_accept = i_dp_vld & any_free & ~i_kill;
    assign issue_rs  = i_ex_accessable & ~i_kill & any_ready;

`ifdef RS_MUL_DP_BYPASS_EN
    // Stored ready entries keep priority; the bypass only fills an idle slot.
    assign bypass = dp_accept & dp_rdy1 & dp_rdy2 & ~any_ready & i_ex_accessable;
`else
    assign bypass = 1'b0;
`endif

    assign alloc = dp_accept & ~bypass;

    // -------------------------------------------------------------------------
    // Next-state: CDB wakeup, issue release, allocation, flush.
    // -------------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        rdy1_d  = rdy1_q;
        rdy2_d  = rdy2_q;
        sgn1_d  = sgn1_q;
        sgn2_d  = sgn2_q;
        selh_d  = selh_q;
        val1_d  = val1_q;
        val2_d  = val2_q;
        tag1_d  = tag1_q;
        tag2_d  = tag2_q;
        rob_d   = rob_q;

        // Both operands of one entry may wake on the same broadcast.
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (valid_q[i] && !rdy1_q[i] && i_cdb_vld && (tag1_q[i] == i_cdb_tag)) begin
                rdy1_d[i] = 1'b1;
                val1_d[i] = i_cdb_data;
            end
            if (valid_q[i] && !rdy2_q[i] && i_cdb_vld && (tag2_q[i] == i_cdb_tag)) begin
                rdy2_d[i] = 1'b1;
                val2_d[i] = i_cdb_data;
            end
        end

        if (issue_rs) begin
            valid_d[is_idx] = 1'b0;
        end

        // The free slot comes from registered state, so it never collides
        // with the entry being issued this cycle.
        if (alloc) begin
            valid_d[free_idx] = 1'b1;
            rdy1_d[free_idx]  = dp_rdy1;
            rdy2_d[free_idx]  = dp_rdy2;
            val1_d[free_idx]  = dp_val1;
            val2_d[free_idx]  = dp_val2;
            tag1_d[free_idx]  = i_dp_src1_tag;
            tag2_d[free_idx]  = i_dp_src2_tag;
            sgn1_d[free_idx]  = i_dp_signed1;
            sgn2_d[free_idx]  = i_dp_signed2;
            selh_d[free_idx]  = i_dp_sel_high;
            rob_d[free_idx]   = i_dp_rob_tag;
        end

        if (i_kill) begin
            valid_d = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rdy1_q  <= rdy1_d;
            rdy2_q  <= rdy2_d;
        end
    end

    always_ff @(posedge clk) begin
        sgn1_q <= sgn1_d;
        sgn2_q <= sgn2_d;
        selh_q <= selh_d;
        val1_q <= val1_d;
        val2_q <= val2_d;
        tag1_q <= tag1_d;
        tag2_q <= tag2_d;
        rob_q  <= rob_d;
    end

    // -------------------------------------------------------------------------
    // Outputs. Payload is forced to zero whenever nothing is issued.
    // -------------------------------------------------------------------------
    always_comb begin
        o_is_vld     = issue_rs | bypass;
        o_signed1    = 1'b0;
        o_signed2    = 1'b0;
        o_sel_high   = 1'b0;
        o_src1       = '0;
        o_src2       = '0;
        o_is_rob_tag = '0;
        if (issue_rs) begin
            o_signed1    = sgn1_q[is_idx];
            o_signed2    = sgn2_q[is_idx];
            o_sel_high   = selh_q[is_idx];
            o_src1       = val1_q[is_idx];
            o_src2       = val2_q[is_idx];
            o_is_rob_tag = rob_q[is_idx];
        end else if (bypass) begin
            o_signed1    = i_dp_signed1;
            o_signed2    = i_dp_signed2;
            o_sel_high   = i_dp_sel_high;
            o_src1       = dp_val1;
            o_src2       = dp_val2;
            o_is_rob_tag = i_dp_rob_tag;
        end
    end

    assign o_dp_ready = any_free;
    assign o_empty    = ~|valid_q;

endmodule

// File: tb/tb_rs_mul.sv
// -----------------------------------------------------------------------------
// tb_rs_mul -- scoreboard bench for rs_mul (default parameters).
// The driver applies one stimulus per cycle, runs a reference model of the
// reservation station, checks status outputs and pushes each expected issue
// into a queue; an independent monitor pops and compares on every o_is_vld.
// -----------------------------------------------------------------------------
module tb_rs_mul;

    localparam int N  = 4;
    localparam int TW = 6;

    logic          clk;
    logic          rst_n;
    logic          i_dp_vld, i_dp_signed1, i_dp_signed2, i_dp_sel_high;
    logic [31:0]   i_dp_src1, i_dp_src2;
    logic          i_dp_src1_rdy, i_dp_src2_rdy;
    logic [TW-1:0] i_dp_src1_tag, i_dp_src2_tag, i_dp_rob_tag;
    logic          i_cdb_vld;
    logic [TW-1:0] i_cdb_tag;
    logic [31:0]   i_cdb_data;
    logic          i_kill, i_ex_accessable;
    logic          o_dp_ready, o_is_vld, o_signed1, o_signed2, o_sel_high, o_empty;
    logic [31:0]   o_src1, o_src2;
    logic [TW-1:0] o_is_rob_tag;

    rs_mul #(.ENTRY_NUM(N), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_dp_vld(i_dp_vld), .o_dp_ready(o_dp_ready),
        .i_dp_signed1(i_dp_signed1), .i_dp_signed2(i_dp_signed2), .i_dp_sel_high(i_dp_sel_high),
        .i_dp_src1(i_dp_src1), .i_dp_src2(i_dp_src2),
        .i_dp_src1_rdy(i_dp_src1_rdy), .i_dp_src2_rdy(i_dp_src2_rdy),
        .i_dp_src1_tag(i_dp_src1_tag), .i_dp_src2_tag(i_dp_src2_tag),
        .i_dp_rob_tag(i_dp_rob_tag),
        .i_cdb_vld(i_cdb_vld), .i_cdb_tag(i_cdb_tag), .i_cdb_data(i_cdb_data),
        .i_kill(i_kill), .i_ex_accessable(i_ex_accessable),
        .o_is_vld(o_is_vld), .o_signed1(o_signed1), .o_signed2(o_signed2),
        .o_sel_high(o_sel_high), .o_src1(o_src1), .o_src2(o_src2),
        .o_is_rob_tag(o_is_rob_tag), .o_empty(o_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          vld, sg1, sg2, sh, r1, r2, cv, kill, acc;
        logic [31:0] s1, s2, cd;
        logic [TW-1:0] t1, t2, rob, ct;
    } stim_t;

    typedef struct {
        bit          v, sg1, sg2, sh, r1, r2;
        logic [31:0] d1, d2;
        logic [TW-1:0] t1, t2, rob;
    } ent_t;

    // expected issue: {sg1, sg2, sh, src1, src2, rob}
    typedef logic [2+1+32+32+TW:0] iss_t;

    ent_t  model [N];
    iss_t  exp_q [$];
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle(input bit acc);
        stim_t s;
        s = '{default: '0};
        s.acc = acc;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        i_dp_vld = s.vld;  i_dp_signed1 = s.sg1; i_dp_signed2 = s.sg2; i_dp_sel_high = s.sh;
        i_dp_src1 = s.s1;  i_dp_src2 = s.s2;
        i_dp_src1_rdy = s.r1; i_dp_src2_rdy = s.r2;
        i_dp_src1_tag = s.t1; i_dp_src2_tag = s.t2; i_dp_rob_tag = s.rob;
        i_cdb_vld = s.cv;  i_cdb_tag = s.ct; i_cdb_data = s.cd;
        i_kill = s.kill;   i_ex_accessable = s.acc;
    endtask

    // Reference model for one cycle: predicts the combinational outputs from
    // the stored entries and the current inputs, then advances the entries.
    task automatic model_cycle(input stim_t s);
        int   ridx = -1, fidx = -1;
        bit   any_v = 0, accept, iss, byp, r1, r2;
        logic [31:0] d1, d2;
        ent_t ne;
        for (int i = 0; i < N; i++) begin
            if (ridx < 0 && model[i].v && model[i].r1 && model[i].r2) ridx = i;
            if (fidx < 0 && !model[i].v) fidx = i;
            if (model[i].v) any_v = 1;
        end
        chk("dp_ready", o_dp_ready, fidx >= 0);
        chk("empty", o_empty, !any_v);

        accept = s.vld && (fidx >= 0) && !s.kill;
        r1 = s.r1 || (s.cv && s.t1 == s.ct);
        r2 = s.r2 || (s.cv && s.t2 == s.ct);
        d1 = s.r1 ? s.s1 : s.cd;
        d2 = s.r2 ? s.s2 : s.cd;
        byp = 0;
`ifdef RS_MUL_DP_BYPASS_EN
        byp = accept && r1 && r2 && (ridx < 0) && s.acc;
`endif
        iss = s.acc && !s.kill && (ridx >= 0);
        chk("is_vld", o_is_vld, iss || byp);
        if (iss)
            exp_q.push_back({model[ridx].sg1, model[ridx].sg2, model[ridx].sh,
                             model[ridx].d1, model[ridx].d2, model[ridx].rob});
        else if (byp)
            exp_q.push_back({s.sg1, s.sg2, s.sh, d1, d2, s.rob});

        for (int i = 0; i < N; i++) begin
            if (model[i].v && s.cv) begin
                if (!model[i].r1 && model[i].t1 == s.ct) begin model[i].r1 = 1; model[i].d1 = s.cd; end
                if (!model[i].r2 && model[i].t2 == s.ct) begin model[i].r2 = 1; model[i].d2 = s.cd; end
            end
        end
        if (iss) model[ridx].v = 0;
        if (accept && !byp) begin
            ne.v = 1; ne.sg1 = s.sg1; ne.sg2 = s.sg2; ne.sh = s.sh;
            ne.r1 = r1; ne.r2 = r2; ne.d1 = d1; ne.d2 = d2;
            ne.t1 = s.t1; ne.t2 = s.t2; ne.rob = s.rob;
            model[fidx] = ne;
        end
        if (s.kill) for (int i = 0; i < N; i++) model[i].v = 0;
    endtask

    task automatic step(input stim_t s);
        @(posedge clk); #1;
        apply(s);
        #1;
        model_cycle(s);
    endtask

    task automatic dp(input logic [31:0] s1, input bit r1, input logic [TW-1:0] t1,
                      input logic [31:0] s2, input bit r2, input logic [TW-1:0] t2,
                      input logic [TW-1:0] rob, input bit acc);
        stim_t s;
        s = idle(acc);
        s.vld = 1; s.s1 = s1; s.r1 = r1; s.t1 = t1; s.s2 = s2; s.r2 = r2; s.t2 = t2; s.rob = rob;
        step(s);
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) model[i].v = 0;
    endtask

    // Monitor: pops an expected issue whenever the DUT presents one.
    iss_t got, want;
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_is_vld) begin
                got = {o_signed1, o_signed2, o_sel_high, o_src1, o_src2, o_is_rob_tag};
                if (exp_q.size() == 0) begin
                    chk("unexpected_issue", got, '0);
                end else begin
                    want = exp_q.pop_front();
                    chk("issue_payload", got, want);
                end
            end else begin
                chk("idle_payload_zero",
                    {o_signed1, o_signed2, o_sel_high, o_src1, o_src2, o_is_rob_tag}, '0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        rst_n = 1'b0;
        apply(idle(1'b1));
        clear_model();
        #3;
        chk("rst_is_vld", o_is_vld, 1'b0);
        chk("rst_empty", o_empty, 1'b1);
        chk("rst_dp_ready", o_dp_ready, 1'b1);
        chk("rst_payload", {o_src1, o_src2, o_is_rob_tag}, '0);
        @(negedge clk); rst_n = 1'b1;

        // basic: 7 x 6, rob 3
        dp(32'd7, 1, '0, 32'd6, 1, '0, 6'd3, 1);
        step(idle(1));
        step(idle(1));

        // src2 waits on tag 9, woken a cycle later with 0x10
        dp(32'd5, 1, '0, 32'd0, 0, 6'd9, 6'd4, 1);
        s = idle(1); s.cv = 1; s.ct = 6'd9; s.cd = 32'h10; step(s);
        step(idle(1));
        step(idle(1));

        // src1 tag 5 captured from CDB in the dispatch cycle
        s = idle(1); s.vld = 1; s.t1 = 6'd5; s.s2 = 32'd2; s.r2 = 1; s.rob = 6'd7;
        s.cv = 1; s.ct = 6'd5; s.cd = 32'hFF; step(s);
        step(idle(1));
        step(idle(1));

        // fill all entries with waiting operands, fifth dispatch is dropped
        for (int k = 0; k < N; k++)
            dp(32'd0, 0, 6'(20 + k), 32'd0, 0, 6'(20 + k), 6'(10 + k), 1);
        dp(32'd1, 1, '0, 32'd1, 1, '0, 6'd31, 1);
        s = idle(1); s.cv = 1; s.ct = 6'd22; s.cd = 32'hABCD; step(s);
        step(idle(1));
        step(idle(1));
        s = idle(1); s.kill = 1; step(s);
        step(idle(1));

        // multiplier busy holds ready entries, then a kill drops them
        for (int k = 0; k < 3; k++)
            dp(32'(100 + k), 1, '0, 32'(200 + k), 1, '0, 6'(40 + k), 0);
        step(idle(0));
        step(idle(0));
        s = idle(1); s.kill = 1; s.vld = 1; s.r1 = 1; s.r2 = 1; s.s1 = 32'd9; step(s);
        step(idle(1));

        // reset in the middle of operation
        dp(32'd0, 0, 6'd50, 32'd1, 1, '0, 6'd1, 0);
        dp(32'd3, 1, '0, 32'd4, 1, '0, 6'd2, 0);
        @(posedge clk); #1; apply(idle(0)); #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        chk("midrst_empty", o_empty, 1'b1);
        chk("midrst_dp_ready", o_dp_ready, 1'b1);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step(idle(1));

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            s.vld  = ($urandom_range(0, 99) < 60);
            s.sg1  = $urandom; s.sg2 = $urandom; s.sh = $urandom;
            s.s1   = $urandom; s.s2 = $urandom; s.cd = $urandom;
            s.r1   = $urandom_range(0, 1); s.r2 = $urandom_range(0, 1);
            s.t1   = TW'($urandom_range(0, 7)); s.t2 = TW'($urandom_range(0, 7));
            s.rob  = TW'($urandom);
            s.cv   = $urandom_range(0, 1); s.ct = TW'($urandom_range(0, 7));
            s.kill = ($urandom_range(0, 99) < 3);
            s.acc  = ($urandom_range(0, 99) < 80);
            step(s);
        end
        s = idle(1); s.kill = 1; step(s);
        step(idle(1));
        @(negedge clk); #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rs_mul.md
RS_MUL -- requirements
Module: rs_mul

Interface
Parameters:
REQ-001 SHALL have parameter ENTRY_NUM, default 4, giving the number of reservation entries (power of two, 2..8).
REQ-002 SHALL have parameter TAG_WIDTH, default 6, giving the ROB tag width.
Ports:
REQ-003 SHALL have ports, one per line:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_dp_vld  input  1  dispatch request
o_dp_ready  output  1  at least one free entry
i_dp_signed1 / i_dp_signed2 / i_dp_sel_high  input  1 each  multiply controls
i_dp_src1 / i_dp_src2  input  32 each  operand values
i_dp_src1_rdy / i_dp_src2_rdy  input  1 each  operand value valid
i_dp_src1_tag / i_dp_src2_tag  input  TAG_WIDTH each  producer tag when not ready
i_dp_rob_tag  input  TAG_WIDTH  destination ROB tag
i_cdb_vld  input  1  result broadcast valid
i_cdb_tag  input  TAG_WIDTH  broadcast tag
i_cdb_data  input  32  broadcast value
i_kill  input  1  pipeline flush
i_ex_accessable  input  1  multiplier accepts issue
o_is_vld  output  1  issue strobe to multiplier
o_signed1 / o_signed2 / o_sel_high  output  1 each  issued controls
o_src1 / o_src2  output  32 each  issued operands
o_is_rob_tag  output  TAG_WIDTH  issued ROB tag
o_empty  output  1  no valid entries

Function
REQ-004 SHALL hold per entry: valid, controls, two operands each with rdy bit, value and tag, and ROB tag.
REQ-005 SHALL accept dispatch when i_dp_vld && o_dp_ready && !i_kill, writing the lowest-indexed free entry at the clock edge.
REQ-006 SHALL ignore dispatch when o_dp_ready is 0; o_dp_ready SHALL reflect the registered state only and SHALL NOT account for a same-cycle issue.
REQ-007 SHALL, when i_cdb_vld and a valid entry's non-ready operand tag equals i_cdb_tag, capture i_cdb_data and set rdy at that edge; both operands SHALL capture if both match.
REQ-008 SHALL apply the same CDB match to the dispatched operands in the dispatch cycle (operand stored ready).
REQ-009 SHALL treat an entry as ready when valid and both rdy bits are set (registered state).
REQ-010 SHALL drive o_is_vld = i_ex_accessable && !i_kill && (any ready entry), combinationally, selecting the lowest-indexed ready entry onto the o_* payload outputs.
REQ-011 SHALL clear the issued entry's valid bit at the edge ending the issue cycle; the freed entry SHALL be reusable from the next cycle.
REQ-012 SHALL issue at most one entry per cycle; minimum dispatch-to-issue latency SHALL be 1 cycle (dispatch edge N, o_is_vld in cycle N+1).
REQ-013 SHALL, on i_kill, clear all valid bits at the next edge, suppress o_is_vld in that cycle and drop any same-cycle dispatch.
REQ-014 SHALL drive o_payload outputs to zero when o_is_vld is 0.
REQ-015 SHALL drive o_empty = 1 exactly when no entry is valid.

Reset
REQ-016 SHALL, on rst_n low, asynchronously clear all entry valid and rdy bits; o_is_vld = 0, o_empty = 1, o_dp_ready = 1, payload outputs 0.
REQ-017 SHALL, on reset mid-operation, discard all entries with no issue after deassertion until a new dispatch.

Configuration
REQ-018 SHALL support macro RS_MUL_DP_BYPASS_EN; when defined, a dispatch with both operands ready (after REQ-008) while no entry is ready and i_ex_accessable = 1 SHALL issue in the dispatch cycle and SHALL NOT allocate an entry.
REQ-019 SHALL, without RS_MUL_DP_BYPASS_EN, always allocate an entry at dispatch (latency per REQ-012).

Verification
REQ-020 Reset, dispatch src1=7, src2=6 both ready, tag 3 -> next cycle o_is_vld=1, o_src1=7, o_src2=6, o_is_rob_tag=3; then o_empty=1.
REQ-021 Dispatch src2 waiting tag 9; cycle later CDB tag 9 data 0x10 -> issue following cycle with o_src2=0x10.
REQ-022 Dispatch with src1 tag 5 while CDB tag 5 data 0xFF same cycle -> issue next cycle, o_src1=0xFF.
REQ-023 Fill 4 entries with unready operands -> o_dp_ready=0; 5th dispatch dropped; wake entry 2 -> it issues, o_dp_ready=1 next cycle.
REQ-024 i_ex_accessable=0 holds ready entries; i_kill with 3 valid entries -> no issue that cycle, o_empty=1 next cycle.
REQ-025 With RS_MUL_DP_BYPASS_EN, empty RS, ready dispatch -> o_is_vld=1 same cycle, o_empty stays 1.
